// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among N_REQ
// valid/ready producers; grants up to BURST_LEN beats and stalls on wfull.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      wfull,
   output logic                      winc,
   output logic [DATA_W-1:0]         wdata,
   output logic                      grant_valid,
   output logic [$clog2(N_REQ)-1:0]  grant_id
);

   localparam int          ID_W  = $clog2(N_REQ);
   localparam int          CNT_W = $clog2(BURST_LEN + 1);
   localparam int unsigned NR    = N_REQ;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_BURST = 1'b1;

   logic             state;
   logic [CNT_W-1:0] beat_cnt;
   logic [ID_W-1:0]  last_id;
   logic [ID_W-1:0]  sel_id;
   logic             in_burst;
   logic             cur_valid;
   logic             burst_end;

   // Scan starts just past the previous winner so it ends up lowest priority.
   always_comb begin
      logic        found;
      int unsigned idx;
      found  = 1'b0;
      sel_id = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= NR; k++) begin
         idx = (32'(last_id) + k) % NR;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            sel_id = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      in_burst  = (state == ST_BURST);
      cur_valid = req_valid[grant_id];
      req_ready = '0;
      if (in_burst)
         req_ready[grant_id] = ~wfull;
      winc        = in_burst & cur_valid & ~wfull;
      wdata       = in_burst ? req_data[grant_id*DATA_W +: DATA_W] : '0;
      grant_valid = in_burst;
      burst_end   = ~cur_valid | (winc & (beat_cnt == CNT_W'(BURST_LEN - 1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         grant_id <= '0;
         beat_cnt <= '0;
         last_id  <= ID_W'(N_REQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  grant_id <= sel_id;
                  beat_cnt <= '0;
                  state    <= ST_BURST;
               end
            end
            default: begin
               if (burst_end) begin
                  state   <= ST_IDLE;
                  last_id <= grant_id;
               end else if (winc) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter that shares the single write port of the async FIFO among `N_REQ` producers in the write clock domain. Each requester presents valid/ready-handshaked data. The arbiter grants one requester at a time for a burst of up to `BURST_LEN` beats. It drives the FIFO write-side increment and data, and it honours the FIFO `wfull` flag. It sits directly in front of the write-side Gray pointer counter and write memory port.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, ≥2.
- `DATA_W`, default 8: data word width.
- `BURST_LEN`, default 4: maximum beats per grant, ≥1.

Ports:
- `clk`, input, 1: write-domain clock. This is the block's only clock.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `req_valid`, input, `N_REQ`: per-requester data valid.
- `req_data`, input, `N_REQ*DATA_W`: requester i's word is at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`, output, `N_REQ`: per-requester accept. A beat transfers when valid and ready are both high.
- `wfull`, input, 1: FIFO full flag, already synchronous to `clk`.
- `winc`, output, 1: FIFO write increment. One FIFO write per cycle high.
- `wdata`, output, `DATA_W`: FIFO write data, valid when `winc` is high.
- `grant_valid`, output, 1: a burst is in progress.
- `grant_id`, output, `$clog2(N_REQ)`: index of the granted requester.

## Operation

- **States:** the block has two states, IDLE and BURST.
  - Registered state: `state`, `grant_id`, `beat_cnt` (width `$clog2(BURST_LEN+1)`), and `last_id`.
- **IDLE:**
  - `grant_valid`=0, `req_ready`=0, `winc`=0.
  - If any `req_valid` is high, select the first valid requester scanning from `(last_id+1) mod N_REQ` upward with wrap.
  - Register the selection into `grant_id`, clear `beat_cnt`, and go to BURST.
  - If no requester is valid, stay in IDLE.
- **BURST:**
  - `grant_valid`=1.
  - `req_ready[grant_id] = ~wfull`; all other `req_ready` bits are 0.
  - `winc = req_valid[grant_id] & ~wfull`.
  - `wdata = req_data[grant_id]`, combinational mux.
  - Each cycle with `winc`=1 increments `beat_cnt`.
- **Burst termination:** go to IDLE and load `last_id <= grant_id` when either condition holds:
  - a beat transfers and `beat_cnt == BURST_LEN-1`, or
  - `req_valid[grant_id]` is 0, regardless of `wfull`.
- **wfull in BURST:**
  - While `wfull`=1: no transfer, `beat_cnt` holds, the grant is held, and other requesters are not served.
  - No timeout.
- **Fairness:** after a burst ends, the previous winner has the lowest priority in the next arbitration.
- **Full/empty policy:** the FIFO's full check is not duplicated here. `winc` is never asserted while `wfull`=1, so no FIFO write is ever attempted on full.
- **Reset:**
  - Values: state=IDLE, `grant_id`=0, `beat_cnt`=0, `last_id=N_REQ-1` (so requester 0 wins first).
  - All outputs are 0.
  - Reset asserted mid-burst aborts immediately. Beats not yet accepted are not written. Accepted beats remain in the FIFO, whose own reset governs them.

## Timing

- The arbitration bubble is 1 cycle: `req_valid` rising in IDLE at cycle n gives `grant_valid`/`req_ready` at n+1. The first beat can be written at n+1.
- Throughput within a burst is 1 beat/cycle while `wfull`=0.
- There is 1 IDLE cycle between consecutive bursts, even when another requester is waiting. Peak utilisation is `BURST_LEN/(BURST_LEN+1)`.
- `req_ready`, `winc` and `wdata` are combinational from registered state plus `wfull`, `req_valid` and `req_data`. There is no combinational path from `req_valid` to `req_ready`.
- `wfull` rising takes effect in the same cycle: `winc` drops that cycle.
- `grant_valid` and `grant_id` are registered. `grant_id` holds its last value while in IDLE.

## Test plan

- **Reset:** hold `rst_n`=0 with all `req_valid`=1 → all outputs 0. After release, requester 0 is granted on the next cycle.
- **Single burst:** requester 2 holds valid with data 0x10..0x13, `wfull`=0, `BURST_LEN`=4 → `winc` high for exactly 4 consecutive cycles with `wdata`=0x10,0x11,0x12,0x13, then `grant_valid`=0 for 1 cycle.
- **Contention:** requesters 0 and 1 are continuously valid → grants alternate 0,1,0,1. Each grant is 4 beats with a 1-cycle gap between bursts, and no requester is starved.
- **wfull stall:** raise `wfull` for 3 cycles after beat 2 of a burst → `winc`=0 and `req_ready`=0 for those 3 cycles, `beat_cnt` holds at 2, and the burst completes with beats 3–4 after `wfull` falls. The FIFO receives exactly 4 words.
- **Early release:** the granted requester drops valid after 2 beats → `winc` stops and the next cycle is IDLE. Another waiting requester is granted one cycle later, and the released requester has lowest priority.
- **Reset mid-burst:** assert `rst_n`=0 after beat 1 → `winc`, `req_ready` and `grant_valid` go 0 immediately (asynchronously). After release, arbitration restarts from requester 0.
